// File: rtl/jstk_input_cond_pkg.sv
// Shared types and frame layout for the PmodJSTK input conditioner.
// Axis FSM encoding, stick centre and DOUT bit-field positions.
package jstk_cond_pkg;

  typedef enum logic [1:0] {StIdle, StFirst, StHold, StRepeat} axis_state_e;

  localparam int unsigned JSTK_CENTER = 512;

  localparam int unsigned X_LO_MSB  = 23;
  localparam int unsigned X_LO_LSB  = 16;
  localparam int unsigned X_HI_MSB  = 9;
  localparam int unsigned X_HI_LSB  = 8;
  localparam int unsigned Y_LO_MSB  = 39;
  localparam int unsigned Y_LO_LSB  = 32;
  localparam int unsigned Y_HI_MSB  = 25;
  localparam int unsigned Y_HI_LSB  = 24;
  localparam int unsigned BTN_C_BIT = 0;
  localparam int unsigned BTN_Z_BIT = 2;

  function automatic logic [9:0] frame_x(logic [39:0] d);
    return {d[X_HI_MSB:X_HI_LSB], d[X_LO_MSB:X_LO_LSB]};
  endfunction

  function automatic logic [9:0] frame_y(logic [39:0] d);
    return {d[Y_HI_MSB:Y_HI_LSB], d[Y_LO_MSB:Y_LO_LSB]};
  endfunction

  function automatic logic [9:0] center_dev(logic [9:0] v);
    if (v >= 10'(JSTK_CENTER)) return v - 10'(JSTK_CENTER);
    else return 10'(JSTK_CENTER) - v;
  endfunction

  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/jstk_input_cond_if.sv
// Frame delivery bus from the PmodJSTK SPI driver.
interface jstk_input_cond_if;
  logic [39:0] jstk_data;
  logic        jstk_valid;

  modport master (output jstk_data, output jstk_valid);
  modport slave  (input jstk_data, input jstk_valid);
endinterface

// File: rtl/jstk_axis_repeat.sv
// One stick axis: hysteresis direction flags, step FSM and hold-to-repeat counter.
module jstk_axis_repeat
  import jstk_cond_pkg::*;
#(
  parameter int unsigned LOW_TH            = 350,
  parameter int unsigned HIGH_TH           = 650,
  parameter int unsigned HYST              = 25,
  parameter int unsigned REPEAT_DELAY_CYC  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD_CYC = 15_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cap,
  input  logic [9:0] value,
  input  logic       qualify,
  output logic       active,
  output logic       step_neg,
  output logic       step_pos
);

  localparam int unsigned CntW = cnt_width(REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC);
  localparam logic [9:0] NegSet = 10'(LOW_TH);
  localparam logic [9:0] NegClr = 10'(LOW_TH + HYST);
  localparam logic [9:0] PosSet = 10'(HIGH_TH);
  localparam logic [9:0] PosClr = 10'(HIGH_TH - HYST);
  localparam logic [CntW-1:0] DelayLoad  = CntW'(REPEAT_DELAY_CYC - 1);
  localparam logic [CntW-1:0] PeriodLoad = CntW'(REPEAT_PERIOD_CYC - 1);

  logic neg_q, neg_d, pos_q, pos_d;
  logic dir_q, dir_d;  // 1: positive side
  axis_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic act_neg, act_pos, hold_act, fire;

  always_comb begin
    neg_d = neg_q;
    pos_d = pos_q;
    if (cap) begin
      if (value < NegSet) neg_d = 1'b1;
      else if (value >= NegClr) neg_d = 1'b0;
      if (value > PosSet) pos_d = 1'b1;
      else if (value <= PosClr) pos_d = 1'b0;
    end
  end

  assign active   = neg_q | pos_q;
  assign act_neg  = neg_q & qualify;
  assign act_pos  = pos_q & qualify;
  assign hold_act = dir_q ? act_pos : act_neg;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      StIdle: begin
        if (act_neg | act_pos) begin
          state_d = StFirst;
          dir_d   = act_pos;
        end
      end
      default: begin
        // A released or reversed side drops out without pulsing.
        if (!hold_act) begin
          if (act_neg | act_pos) begin
            state_d = StFirst;
            dir_d   = act_pos;
          end else begin
            state_d = StIdle;
          end
        end else if (state_q == StFirst) begin
          fire    = 1'b1;
          cnt_d   = DelayLoad;
          state_d = StHold;
        end else if (cnt_q == '0) begin
          fire    = 1'b1;
          cnt_d   = PeriodLoad;
          state_d = StRepeat;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  assign step_neg = fire & ~dir_q;
  assign step_pos = fire & dir_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_q   <= 1'b0;
      pos_q   <= 1'b0;
      dir_q   <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      neg_q   <= neg_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/jstk_input_cond.sv
// PmodJSTK frame conditioner: captured axes, repeating step pulses, debounced buttons.
// Define JSTK_DIAG_EN to let both axes step at once; otherwise only the dominant axis steps.
module jstk_input_cond
  import jstk_cond_pkg::*;
#(
  parameter int unsigned LOW_TH            = 350,
  parameter int unsigned HIGH_TH           = 650,
  parameter int unsigned HYST              = 25,
  parameter int unsigned REPEAT_DELAY_CYC  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD_CYC = 15_000_000,
  parameter int unsigned DEB_FRAMES        = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  jstk_input_cond_if.slave  jstk,
  output logic [9:0]        joy_x,
  output logic [9:0]        joy_y,
  output logic              step_left,
  output logic              step_right,
  output logic              step_up,
  output logic              step_down,
  output logic              btn_c_level,
  output logic              btn_z_level,
  output logic              btn_c_pulse,
  output logic              btn_z_pulse
);

  localparam int unsigned DebW = $clog2(DEB_FRAMES + 1);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_FRAMES - 1);

  logic [9:0] joy_x_q, joy_y_q;
  logic [1:0] raw, lvl_q, lvl_d, pulse_q, pulse_d;  // [0]: C, [1]: Z
  logic [1:0][DebW-1:0] deb_q, deb_d;
  logic act_x, act_y, qual_x, qual_y;

  logic unused_frame;
  assign unused_frame = ^{jstk.jstk_data[1], jstk.jstk_data[7:3], jstk.jstk_data[15:10],
                          jstk.jstk_data[31:26]};

  assign raw = {jstk.jstk_data[BTN_Z_BIT], jstk.jstk_data[BTN_C_BIT]};

  always_comb begin
    lvl_d   = lvl_q;
    deb_d   = deb_q;
    pulse_d = '0;
    if (jstk.jstk_valid) begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] != lvl_q[i]) begin
          if (deb_q[i] == DebLast) begin
            lvl_d[i]   = raw[i];
            deb_d[i]   = '0;
            pulse_d[i] = raw[i];
          end else begin
            deb_d[i] = deb_q[i] + 1'b1;
          end
        end else begin
          deb_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy_x_q <= '0;
      joy_y_q <= '0;
      lvl_q   <= '0;
      deb_q   <= '0;
      pulse_q <= '0;
    end else begin
      if (jstk.jstk_valid) begin
        joy_x_q <= frame_x(jstk.jstk_data);
        joy_y_q <= frame_y(jstk.jstk_data);
      end
      lvl_q   <= lvl_d;
      deb_q   <= deb_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef JSTK_DIAG_EN
  logic unused_act;
  assign unused_act = act_x ^ act_y;
  assign qual_x = 1'b1;
  assign qual_y = 1'b1;
`else
  logic dom_y;
  // Ties favour X.
  assign dom_y  = center_dev(joy_y_q) > center_dev(joy_x_q);
  assign qual_x = !(act_x && act_y && dom_y);
  assign qual_y = !(act_x && act_y && !dom_y);
`endif

  jstk_axis_repeat #(
    .LOW_TH           (LOW_TH),
    .HIGH_TH          (HIGH_TH),
    .HYST             (HYST),
    .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
    .REPEAT_PERIOD_CYC(REPEAT_PERIOD_CYC)
  ) u_axis_x (
    .clk     (clk),
    .reset_n (reset_n),
    .cap     (jstk.jstk_valid),
    .value   (frame_x(jstk.jstk_data)),
    .qualify (qual_x),
    .active  (act_x),
    .step_neg(step_left),
    .step_pos(step_right)
  );

  jstk_axis_repeat #(
    .LOW_TH           (LOW_TH),
    .HIGH_TH          (HIGH_TH),
    .HYST             (HYST),
    .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
    .REPEAT_PERIOD_CYC(REPEAT_PERIOD_CYC)
  ) u_axis_y (
    .clk     (clk),
    .reset_n (reset_n),
    .cap     (jstk.jstk_valid),
    .value   (frame_y(jstk.jstk_data)),
    .qualify (qual_y),
    .active  (act_y),
    .step_neg(step_up),
    .step_pos(step_down)
  );

  assign joy_x       = joy_x_q;
  assign joy_y       = joy_y_q;
  assign btn_c_level = lvl_q[0];
  assign btn_z_level = lvl_q[1];
  assign btn_c_pulse = pulse_q[0];
  assign btn_z_pulse = pulse_q[1];

endmodule

// File: tb/tb_jstk_input_cond.sv
// Bench for jstk_input_cond with shrunk repeat timing; reference model tracks expected
// pulse times per held direction rather than FSM states.
module tb_jstk_input_cond;

  localparam int Delay  = 20;
  localparam int Period = 5;
  localparam int Deb    = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic [9:0] joy_x, joy_y;
  logic step_left, step_right, step_up, step_down;
  logic btn_c_level, btn_z_level, btn_c_pulse, btn_z_pulse;

  always #5 clk = ~clk;

  jstk_input_cond_if jstk ();

  jstk_input_cond #(
    .LOW_TH           (350),
    .HIGH_TH          (650),
    .HYST             (25),
    .REPEAT_DELAY_CYC (Delay),
    .REPEAT_PERIOD_CYC(Period),
    .DEB_FRAMES       (Deb)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .jstk       (jstk),
    .joy_x      (joy_x),
    .joy_y      (joy_y),
    .step_left  (step_left),
    .step_right (step_right),
    .step_up    (step_up),
    .step_down  (step_down),
    .btn_c_level(btn_c_level),
    .btn_z_level(btn_z_level),
    .btn_c_pulse(btn_c_pulse),
    .btn_z_pulse(btn_z_pulse)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int t = 0;

  // Reference model state
  int mx, my;
  bit lf, rf, uf, df;
  int tgt_x, tgt_y, cur_x, cur_y, first_x, first_y, pend_x, pend_y, pdir_x, pdir_y;
  bit mc_l, mz_l, mc_p, mz_p;
  int mc_n, mz_n;
  bit prev_v;
  logic [39:0] prev_d;

  function automatic logic [39:0] rnd40();
    logic [39:0] d;
    d[31:0]  = $urandom;
    d[39:32] = 8'($urandom);
    return d;
  endfunction

  function automatic logic [39:0] mk(int x, int y, bit c, bit z);
    logic [39:0] d;
    logic [9:0] xv, yv;
    xv = 10'(x);
    yv = 10'(y);
    d = rnd40();
    d[9:8]   = xv[9:8];
    d[23:16] = xv[7:0];
    d[25:24] = yv[9:8];
    d[39:32] = yv[7:0];
    d[0]     = c;
    d[2]     = z;
    return d;
  endfunction

  function automatic int dev(int v);
    return (v >= 512) ? v - 512 : 512 - v;
  endfunction

  function automatic bit rep_hit(int k);
    return (k == 0) || (k >= Delay && ((k - Delay) % Period) == 0);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic model_clear();
    mx = 0; my = 0;
    lf = 0; rf = 0; uf = 0; df = 0;
    tgt_x = 0; tgt_y = 0; cur_x = 0; cur_y = 0;
    first_x = 0; first_y = 0; pend_x = -1; pend_y = -1; pdir_x = 0; pdir_y = 0;
    mc_l = 0; mz_l = 0; mc_p = 0; mz_p = 0; mc_n = 0; mz_n = 0;
  endtask

  task automatic deb_update(input bit raw, inout bit lvl, inout int n, output bit p);
    p = 0;
    if (raw != lvl) begin
      n++;
      if (n == Deb) begin
        lvl = raw;
        n = 0;
        p = raw;
      end
    end else begin
      n = 0;
    end
  endtask

  // Applies the frame captured at the previous edge; onset is visible one cycle after
  // release so a step lands two cycles after its frame.
  task automatic model_step();
    int x, y, qx, qy;
    mc_p = 0;
    mz_p = 0;
    if (prev_v) begin
      x = int'({prev_d[9:8], prev_d[23:16]});
      y = int'({prev_d[25:24], prev_d[39:32]});
      if (x < 350) lf = 1; else if (x >= 375) lf = 0;
      if (x > 650) rf = 1; else if (x <= 625) rf = 0;
      if (y < 350) uf = 1; else if (y >= 375) uf = 0;
      if (y > 650) df = 1; else if (y <= 625) df = 0;
      mx = x;
      my = y;
      deb_update(prev_d[0], mc_l, mc_n, mc_p);
      deb_update(prev_d[2], mz_l, mz_n, mz_p);
      qx = lf ? -1 : (rf ? 1 : 0);
      qy = uf ? -1 : (df ? 1 : 0);
`ifndef JSTK_DIAG_EN
      if (qx != 0 && qy != 0) begin
        if (dev(my) > dev(mx)) qx = 0;
        else qy = 0;
      end
`endif
      if (qx != tgt_x) begin
        tgt_x = qx; cur_x = 0; pdir_x = qx;
        pend_x = (qx != 0) ? t + 1 : -1;
      end
      if (qy != tgt_y) begin
        tgt_y = qy; cur_y = 0; pdir_y = qy;
        pend_y = (qy != 0) ? t + 1 : -1;
      end
    end
    if (pend_x == t) begin cur_x = pdir_x; first_x = t; pend_x = -1; end
    if (pend_y == t) begin cur_y = pdir_y; first_y = t; pend_y = -1; end
  endtask

  task automatic cyc(input bit rn, input bit v, input logic [39:0] d);
    bit hx, hy;
    reset_n = rn;
    jstk.jstk_valid = v;
    jstk.jstk_data = d;
    @(negedge clk);
    if (!reset_n) begin
      model_clear();
      prev_v = 0;
    end else begin
      model_step();
      prev_v = v;
      prev_d = d;
    end
    hx = (cur_x != 0) && rep_hit(t - first_x);
    hy = (cur_y != 0) && rep_hit(t - first_y);
    check("joy_xy", {joy_x, joy_y}, {10'(mx), 10'(my)});
    check("steps", {step_left, step_right, step_up, step_down},
          {hx && cur_x < 0, hx && cur_x > 0, hy && cur_y < 0, hy && cur_y > 0});
    check("btn_level", {btn_c_level, btn_z_level}, {mc_l, mz_l});
    check("btn_pulse", {btn_c_pulse, btn_z_pulse}, {mc_p, mz_p});
    check("opposite", (step_left & step_right) | (step_up & step_down), 0);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1, 0, rnd40());
  endtask

  task automatic send(int x, int y, bit c, bit z, int gap);
    cyc(1, 1, mk(x, y, c, z));
    idle((gap < 3) ? 3 : gap);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 1023));
      1: return int'($urandom_range(320, 400));
      2: return int'($urandom_range(600, 680));
      default: return 512;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    jstk.jstk_valid = 1'b0;
    jstk.jstk_data = '0;
    model_clear();
    prev_v = 0;
    prev_d = '0;
    @(posedge clk);
    #1;

    // Reset with random frames, then quiet after release
    repeat (5) cyc(0, 1'($urandom), rnd40());
    idle(6);

    // Hold left: first step, delayed repeat, periodic repeats; hysteresis hold then release
    repeat (12) send(100, 512, 0, 0, 3);
    repeat (4) send(370, 512, 0, 0, 3);
    send(380, 512, 0, 0, 10);

    // Reversal within one frame
    send(300, 512, 0, 0, 6);
    send(700, 512, 0, 0, 6);
    send(512, 512, 0, 0, 6);

    // Button debounce
    send(512, 512, 1, 0, 4);
    send(512, 512, 0, 0, 4);
    repeat (4) send(512, 512, 1, 0, 4);
    repeat (3) send(512, 512, 0, 0, 4);
    repeat (3) send(512, 512, 1, 1, 3);
    repeat (3) send(512, 512, 0, 0, 3);

    // Diagonal and dominance swap
    repeat (8) send(100, 1000, 0, 0, 3);
    send(512, 512, 0, 0, 6);
    repeat (3) send(50, 900, 0, 0, 3);
    repeat (3) send(50, 1023, 0, 0, 3);
    send(512, 512, 0, 0, 6);

    // Reset mid-repeat, then restart from a new frame
    repeat (9) send(100, 512, 0, 0, 3);
    repeat (3) cyc(0, 1'($urandom), rnd40());
    idle(30);
    send(100, 512, 0, 0, 6);
    send(512, 512, 0, 0, 4);

    // Random frames
    repeat (80) send(pick(), pick(), 1'($urandom), 1'($urandom), int'($urandom_range(3, 8)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
